onefour_demux: RTL
==================

# onefour_demux

Registered 1-to-4 demultiplexer for 16-bit datapath words: the distributing counterpart of the 4-to-1 operand select mux. One producer supplies a word and a 2-bit select. The block routes the word into a one-entry holding register on the selected output port. Each port carries a valid/ready handshake toward its consumer, and the block counts the words delivered per port.

## Interface
- `WIDTH`, 16, data word width.
- `CNTW`, 8, width of each per-port delivered-word counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  input word.
- `sel`  in  2  destination port (0..3) for `din`.
- `in_valid`  in  1  producer offers `din`/`sel` this cycle.
- `in_ready`  out  1  block accepts this cycle (combinational).
- `y0`..`y3`  out  WIDTH each  port holding-register contents.
- `v0`..`v3`  out  1 each  port holds an undelivered word.
- `r0`..`r3`  in  1 each  consumer of port i takes the word this cycle.
- `cnt0`..`cnt3`  out  CNTW each  words delivered on port i, wrapping.

## Operation
- Per port i: one-entry buffer made of data register `yi` and flag `vi`.
- Port i is free when `vi`==0 or `ri`==1 (draining this cycle).
- `in_ready` = port[`sel`] is free. It depends only on `sel`, `v[sel]` and `r[sel]`, never on `in_valid`.
- Accept: `in_valid && in_ready` at a rising edge. `y[sel]` <= `din`, and `v[sel]` <= 1.
- Deliver on port i: `vi && ri` at a rising edge. `cnti` <= `cnti`+1 mod 2^CNTW.
  - If the same edge also accepts a word into port i, `vi` stays 1 and `yi` takes the new word.
  - Otherwise `vi` <= 0.
- Non-selected ports are unaffected by `din`/`sel`. Their own drains proceed independently, and all four may drain on the same edge.
- `ri` asserted while `vi`==0 is ignored: no count, no state change.
- `yi` holds its last value after delivery. Consumers qualify it with `vi`.
- Producer rule: while `in_valid`=1 and `in_ready`=0, the producer holds `din`/`sel` stable. The block does not check this.
- No data is ever dropped or overwritten while `vi`=1 and `ri`=0.

## Timing
- Reset (async assert, sampled release): all `yi`=0, `vi`=0, `cnti`=0.
  - `in_ready` then reflects an empty port, so it is 1 for any `sel` the cycle after reset release.
  - Reset mid-operation discards all held words with no count increment.
- Latency: a word accepted at edge k is visible on `y[sel]` with `v[sel]`=1 in the cycle after edge k. Latency is 1 cycle.
- Throughput:
  - 1 word/cycle into a single port whose consumer holds `ri`=1 continuously.
  - 1 word/cycle overall when rotating `sel` across ports.
- Counter increments on the delivery edge. Value 2^CNTW-1 wraps to 0. No saturation, no flag.
- No combinational path from `din` to any output. `in_ready` is combinational from `sel`, `vi`, `ri` only.

## Test plan
- Reset/idle: assert `rst` mid-cycle, with no clock edge needed.
  - Required response: all `y`=0, `v`=0, `cnt`=0 immediately.
  - After release with `sel`=2, `in_valid`=0: `in_ready`=1.
- Routing: all `r`=1; send 50,100,5000,10000 with `sel`=0,1,2,3 on consecutive cycles.
  - Required response: each word appears one cycle later on y0..y3 respectively, with its `v` pulsing for one cycle.
  - Then `cnt0`..`cnt3`=1 each.
- Backpressure: `r1`=0; send 100 to `sel`=1.
  - Required response: `v1`=1 and `y1`=100.
  - A second offer of 200 to `sel`=1 sees `in_ready`=0 and is held for 3 cycles; `y1` stays 100.
  - Raising `r1` delivers 100 (`cnt1`=1). The same edge loads 200, and `v1` stays 1.
- Independence: `v0`=1 stalled (`r0`=0); offer 7 to `sel`=3 with `r3`=1.
  - Required response: `in_ready`=1, and the word is accepted and delivered on port 3.
  - Port 0 is unchanged.
- Spurious ready: `r2`=1 with `v2`=0 for 5 cycles.
  - Required response: `cnt2` is unchanged and `v2` stays 0.
- Wrap and reset: deliver 256 words on port 0 (CNTW=8).
  - Required response: `cnt0`=0.
  - Then stall a word in port 0 and assert `rst`: `v0`=0 and `y0`=0, and the word is lost.

Source files
------------

// File: rtl/onefour_demux.sv
// Registered 1-to-4 demultiplexer: routes din into a one-entry holding register on port sel.
// Latency 1 cycle from accept edge to y[sel]/v[sel]; per-port delivered-word counters wrap.
// Backpressure: in_ready = port[sel] empty or draining this cycle; held words never overwritten.
module onefour_demux #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1,
  output logic [CNTW-1:0]  cnt2,
  output logic [CNTW-1:0]  cnt3
);

  logic [WIDTH-1:0] r_y   [4];
  logic [3:0]       r_v;
  logic [CNTW-1:0]  r_cnt [4];

  logic [3:0] w_rdy;
  logic [3:0] w_free;
  logic [3:0] w_load;
  logic [3:0] w_deliv;
  logic       w_acc;

  assign w_rdy = {r3, r2, r1, r0};

  // Port status and accept/deliver strobes; in_ready never looks at in_valid or din
  always_comb begin
    w_free   = ~r_v | w_rdy;
    w_deliv  = r_v & w_rdy;
    in_ready = w_free[sel];
    w_acc    = in_valid & in_ready;
    w_load   = '0;
    w_load[sel] = w_acc;
  end

  // Holding registers, valid flags and delivery counters; a load wins over a drain on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < 4; i++) begin
        r_y[i]   <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_deliv[i]) begin
          r_cnt[i] <= r_cnt[i] + CNTW'(1);
        end
        if (w_load[i]) begin
          r_y[i] <= din;
          r_v[i] <= 1'b1;
        end else if (w_deliv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];

  assign v0 = r_v[0];
  assign v1 = r_v[1];
  assign v2 = r_v[2];
  assign v3 = r_v[3];

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule
